execute_stage: RTL and testbench

//  Y86-64 execute stage. It sits downstream of decode and upstream of memory, and wraps the 64-bit add/sub/and/xor units.

---
 rtl/execute_stage.sv | 108 ++++++++++
 tb/tb_execute_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 execute stage computing valE, the ZF/SF/OF condition codes and cnd.
// One registered stage with valid/stall handshake and a RUN/HALTED state machine.
module execute_stage #(
    parameter int W       = 64,
    parameter int STK_INC = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         stall,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] valA,
    input  logic [W-1:0] valB,
    input  logic [W-1:0] valC,
    output logic         out_valid,
    output logic [W-1:0] valE,
    output logic         cnd,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         halted,
    output logic         instr_err
);
    localparam logic [3:0] I_HALT = 4'h0, I_RRMOV = 4'h2, I_IRMOV = 4'h3, I_RMMOV = 4'h4,
                           I_MRMOV = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8,
                           I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;
    typedef enum logic {RUN, HALTED} state_t;
    state_t       state_q;
    logic         out_valid_q, cnd_q, zf_q, sf_q, of_q, halted_q, instr_err_q;
    logic [W-1:0] vale_q;
    logic         accept, is_opq, is_cond, legal;
    logic [W-1:0] add_res, sub_res, opq_res, vale_d;
    logic         zf_d, sf_d, of_d, cond_hit, cnd_d;
    always_comb begin
        accept  = in_valid & ~stall & (state_q == RUN);
        is_opq  = icode == I_OPQ;
        is_cond = (icode == I_RRMOV) | (icode == I_JXX);
        legal   = (icode <= I_POP) & ~(is_opq & (ifun > 4'd3)) & ~(is_cond & (ifun > 4'd6));
        add_res = valB + valA;
        sub_res = valB - valA;
        opq_res = ifun[1:0] == 2'd0 ? add_res :
                  ifun[1:0] == 2'd1 ? sub_res :
                  ifun[1:0] == 2'd2 ? (valB & valA) : (valB ^ valA);
        vale_d  = W'(0);
        case (icode)
            I_RRMOV:          vale_d = valA;
            I_IRMOV:          vale_d = valC;
            I_RMMOV, I_MRMOV: vale_d = valB + valC;
            I_OPQ:            vale_d = opq_res;
            I_CALL, I_PUSH:   vale_d = valB - W'(STK_INC);
            I_RET, I_POP:     vale_d = valB + W'(STK_INC);
            default:          vale_d = W'(0);
        endcase
        // Overflow only exists for add/sub; the signs of the ALU operands decide it.
        zf_d = opq_res == W'(0);
        sf_d = opq_res[W-1];
        of_d = ifun == 4'd0 ? (valA[W-1] == valB[W-1]) & (opq_res[W-1] != valB[W-1]) :
               ifun == 4'd1 ? (valA[W-1] != valB[W-1]) & (opq_res[W-1] != valB[W-1]) : 1'b0;
        // Conditions read the registered CC, i.e. flags from before this instruction.
        cond_hit = ifun == 4'd0 ? 1'b1 :
                   ifun == 4'd1 ? (sf_q ^ of_q) | zf_q :
                   ifun == 4'd2 ? sf_q ^ of_q :
                   ifun == 4'd3 ? zf_q :
                   ifun == 4'd4 ? ~zf_q :
                   ifun == 4'd5 ? ~(sf_q ^ of_q) :
                   ifun == 4'd6 ? ~(sf_q ^ of_q) & ~zf_q : 1'b0;
        cnd_d = legal & is_cond & cond_hit;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            vale_q      <= W'(0);
            cnd_q       <= 1'b0;
            zf_q        <= 1'b1;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
            halted_q    <= 1'b0;
            instr_err_q <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= accept;
            if (accept) begin
                vale_q <= legal ? vale_d : W'(0);
                cnd_q  <= cnd_d;
                if (!legal)
                    instr_err_q <= 1'b1;
                if (legal && is_opq) begin
                    zf_q <= zf_d;
                    sf_q <= sf_d;
                    of_q <= of_d;
                end
                if (icode == I_HALT) begin
                    state_q  <= HALTED;
                    halted_q <= 1'b1;
                end
            end
        end
    end
    assign out_valid = out_valid_q;
    assign valE      = vale_q;
    assign cnd       = cnd_q;
    assign zf        = zf_q;
    assign sf        = sf_q;
    assign of        = of_q;
    assign halted    = halted_q;
    assign instr_err = instr_err_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors for execute_stage, checked every cycle against an
// instruction-level reference model plus hand-computed literal expectations.
module tb_execute_stage;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, stall = 1'b0;
    logic [3:0]  icode = 4'h1, ifun = 4'h0;
    logic [63:0] valA = '0, valB = '0, valC = '0;
    logic        out_valid, cnd, zf, sf, of, halted, instr_err;
    logic [63:0] valE;
    int checks = 0, errors = 0;

    execute_stage #(.W(64), .STK_INC(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .icode(icode), .ifun(ifun),
        .valA(valA), .valB(valB), .valC(valC), .out_valid(out_valid), .valE(valE), .cnd(cnd),
        .zf(zf), .sf(sf), .of(of), .halted(halted), .instr_err(instr_err));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: instruction semantics stated as plain arithmetic.
    logic        m_init = 1'b0, m_ov, m_cnd, m_zf, m_sf, m_of, m_halt, m_err;
    logic [63:0] m_vale;

    function automatic logic m_legal(input logic [3:0] ic, input logic [3:0] fn);
        if (ic > 4'hB) return 1'b0;
        if (ic == 4'h6) return fn <= 4'd3;
        if (ic == 4'h2 || ic == 4'h7) return fn <= 4'd6;
        return 1'b1;
    endfunction

    function automatic logic m_cond(input logic [3:0] fn, input logic z, input logic s, input logic o);
        logic lt;
        lt = s ^ o;
        case (fn)
            4'd0: return 1'b1;
            4'd1: return lt || z;
            4'd2: return lt;
            4'd3: return z;
            4'd4: return !z;
            4'd5: return !lt;
            4'd6: return !lt && !z;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [64:0] wide;
        logic [63:0] r;
        if (rst) begin
            m_init = 1'b1; m_ov = 0; m_vale = 0; m_cnd = 0;
            m_zf = 1; m_sf = 0; m_of = 0; m_halt = 0; m_err = 0;
        end else if (m_init && !stall) begin
            m_ov = in_valid && !m_halt;
            if (m_ov) begin
                if (!m_legal(icode, ifun)) begin
                    m_err = 1; m_vale = 0; m_cnd = 0;
                end else begin
                    m_cnd = (icode == 4'h2 || icode == 4'h7) ? m_cond(ifun, m_zf, m_sf, m_of) : 1'b0;
                    case (icode)
                        4'h2: m_vale = valA;
                        4'h3: m_vale = valC;
                        4'h4, 4'h5: m_vale = valB + valC;
                        4'h8, 4'hA: m_vale = valB - 64'd8;
                        4'h9, 4'hB: m_vale = valB + 64'd8;
                        default: m_vale = 0;
                    endcase
                    if (icode == 4'h0) m_halt = 1;
                    if (icode == 4'h6) begin
                        wide = 0;
                        if (ifun == 0) wide = {valB[63], valB} + {valA[63], valA};
                        if (ifun == 1) wide = {valB[63], valB} - {valA[63], valA};
                        if (ifun == 2) wide = {1'b0, valB & valA};
                        if (ifun == 3) wide = {1'b0, valB ^ valA};
                        r = wide[63:0];
                        m_vale = r;
                        m_zf = (r == 0);
                        m_sf = r[63];
                        m_of = (ifun <= 1) ? (wide[64] != wide[63]) : 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("valE", valE, m_vale);
            chk("cnd", 64'(cnd), 64'(m_cnd));
            chk("cc", {61'd0, zf, sf, of}, {61'd0, m_zf, m_sf, m_of});
            chk("halted", 64'(halted), 64'(m_halt));
            chk("instr_err", 64'(instr_err), 64'(m_err));
        end
    end

    task automatic cyc(input logic r, input logic v, input logic s, input logic [3:0] ic,
                       input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c);
        @(negedge clk);
        rst = r; in_valid = v; stall = s; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(1, 0, 0, 4'h1, 0, 0, 0, 0);
        cyc(1, 1, 1, 4'h6, 0, 1, 1, 0);
        chk("rst_ov", 64'(out_valid), 0);
        chk("rst_valE", valE, 0);
        chk("rst_cc", {61'd0, zf, sf, of}, 64'b100);
        chk("rst_flags", {62'd0, halted, instr_err}, 0);
        cyc(0, 1, 0, 4'h6, 4'd2, 64'd8238, 64'd1134, 0);
        chk("and_valE", valE, 64'd46);
        chk("and_ov_cc", {60'd0, out_valid, zf, sf, of}, 64'b1000);
        cyc(0, 0, 0, 4'h6, 4'd0, 5, 5, 0);
        chk("idle_ov", 64'(out_valid), 0);
        chk("idle_hold", valE, 64'd46);
        cyc(0, 1, 0, 4'h6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0);
        chk("add_valE", valE, 64'h8000_0000_0000_0000);
        chk("add_cc", {61'd0, zf, sf, of}, 64'b011);
        cyc(0, 1, 0, 4'h2, 4'd2, 64'd77, 0, 0);
        chk("cmovl_cnd", 64'(cnd), 0);
        chk("cmov_valE", valE, 64'd77);
        cyc(0, 1, 0, 4'h7, 4'd0, 0, 0, 0);
        chk("jmp_cnd", 64'(cnd), 1);
        cyc(0, 1, 0, 4'h6, 4'd1, 64'd5, 64'd5, 0);
        chk("sub_valE", valE, 0);
        chk("sub_cc", {61'd0, zf, sf, of}, 64'b100);
        cyc(0, 1, 0, 4'h7, 4'd3, 0, 0, 0);
        chk("je_cnd", 64'(cnd), 1);
        cyc(0, 1, 0, 4'h7, 4'd4, 0, 0, 0);
        chk("jne_cnd", 64'(cnd), 0);
        chk("jxx_zf", 64'(zf), 1);
        cyc(0, 1, 0, 4'h8, 0, 0, 64'h100, 0);
        chk("call_valE", valE, 64'hF8);
        cyc(0, 1, 0, 4'hB, 0, 0, 64'hF8, 0);
        chk("pop_valE", valE, 64'h100);
        chk("stack_cc", {61'd0, zf, sf, of}, 64'b100);
        cyc(0, 1, 0, 4'h3, 0, 0, 0, 64'd1234);
        chk("irmov_valE", valE, 64'd1234);
        cyc(0, 1, 0, 4'h5, 0, 0, 64'd10, 64'd20);
        chk("mrmov_valE", valE, 64'd30);
        cyc(0, 1, 0, 4'h6, 4'd1, 64'd5, 64'd3, 0);
        chk("subneg_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
        cyc(0, 1, 0, 4'h7, 4'd5, 0, 0, 0);
        chk("jge_cnd", 64'(cnd), 0);
        cyc(0, 1, 0, 4'h7, 4'd2, 0, 0, 0);
        chk("jl_cnd", 64'(cnd), 1);
        cyc(0, 1, 0, 4'h6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 0);
        chk("subovf_valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("subovf_cc", {61'd0, zf, sf, of}, 64'b001);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 4'h6, 4'd3, 64'hF0, 64'hFF, 0);
        chk("stall_valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("stall_ov_of", {62'd0, out_valid, of}, 64'b11);
        cyc(0, 1, 0, 4'h6, 4'd3, 64'hF0, 64'hFF, 0);
        chk("xor_valE", valE, 64'h0F);
        chk("xor_cc", {61'd0, zf, sf, of}, 0);
        cyc(0, 1, 1, 4'h6, 4'd0, 1, 1, 0);
        cyc(1, 1, 1, 4'h6, 4'd0, 1, 1, 0);
        chk("rststall_valE", valE, 0);
        chk("rststall_ov", 64'(out_valid), 0);
        cyc(0, 1, 0, 4'hC, 0, 1, 2, 3);
        chk("illegal_err", 64'(instr_err), 1);
        chk("illegal_valE", valE, 0);
        chk("illegal_ov", 64'(out_valid), 1);
        cyc(0, 1, 0, 4'h6, 4'd4, 1, 2, 0);
        cyc(0, 1, 0, 4'h2, 4'd7, 9, 0, 0);
        chk("illcmov_valE", valE, 0);
        cyc(0, 1, 0, 4'h6, 4'd0, 2, 3, 0);
        chk("sticky_err", 64'(instr_err), 1);
        chk("after_err_valE", valE, 5);
        cyc(1, 0, 0, 4'h1, 0, 0, 0, 0);
        cyc(0, 1, 0, 4'h6, 4'd1, 7, 7, 0);
        cyc(0, 1, 0, 4'h0, 0, 0, 0, 0);
        chk("halt_flag", 64'(halted), 1);
        chk("halt_ov_valE", {out_valid, valE[62:0]}, 64'h8000_0000_0000_0000);
        cyc(0, 1, 1, 4'h6, 4'd0, 1, 1, 0);
        chk("halt_stall_ov", 64'(out_valid), 1);
        cyc(0, 1, 0, 4'h6, 4'd0, 1, 1, 0);
        chk("halt_ign_ov", 64'(out_valid), 0);
        chk("halt_cc", {61'd0, zf, sf, of}, 64'b100);
        cyc(0, 1, 0, 4'h3, 0, 0, 0, 64'd9);
        chk("halt_valE", valE, 0);
        cyc(0, 0, 0, 4'h1, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
